// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and Q12 cosine table for the 8x8 DCT/IDCT pair
package dct_pkg;

  localparam int COEF_W    = 13;
  localparam int MID_W     = 16;
  localparam int COEF_IN_W = 15;
  localparam int SAMPLE_W  = 8;
  localparam int LATENCY   = 83;

  typedef logic signed [COEF_W-1:0] coef_t;

  // IDCT_C[n][k]: round(4096 * c(k)/2 * cos((2n+1)k*pi/16)), transpose of the forward table
  localparam coef_t IDCT_C [8][8] = '{
    '{13'sd1448,  13'sd2009,  13'sd1892,  13'sd1703,  13'sd1448,  13'sd1138,  13'sd784,   13'sd400},
    '{13'sd1448,  13'sd1703,  13'sd784,  -13'sd400,  -13'sd1448, -13'sd2009, -13'sd1892, -13'sd1138},
    '{13'sd1448,  13'sd1138, -13'sd784,  -13'sd2009, -13'sd1448,  13'sd400,   13'sd1892,  13'sd1703},
    '{13'sd1448,  13'sd400,  -13'sd1892, -13'sd1138,  13'sd1448,  13'sd1703, -13'sd784,  -13'sd2009},
    '{13'sd1448, -13'sd400,  -13'sd1892,  13'sd1138,  13'sd1448, -13'sd1703, -13'sd784,   13'sd2009},
    '{13'sd1448, -13'sd1138, -13'sd784,   13'sd2009, -13'sd1448, -13'sd400,   13'sd1892, -13'sd1703},
    '{13'sd1448, -13'sd1703,  13'sd784,   13'sd400,  -13'sd1448,  13'sd2009, -13'sd1892,  13'sd1138},
    '{13'sd1448, -13'sd2009,  13'sd1892, -13'sd1703,  13'sd1448, -13'sd1138,  13'sd784,  -13'sd400}
  };

endpackage

// File: rtl/idct_1d.sv
// rtl/idct_1d.sv - 8-MAC serial-in/serial-out 1D IDCT stage with round and saturate
module idct_1d
  import dct_pkg::*;
#(
  parameter int IN_W    = 15,
  parameter int ACC_W   = 31,
  parameter int OUT_W   = 16,
  parameter int SAT_MIN = -32768,
  parameter int SAT_MAX = 32767
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [2:0]              phase,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam int SH_W   = ACC_W - 11;
  localparam logic signed [SH_W-1:0]  SH_MAX = SH_W'(SAT_MAX);
  localparam logic signed [SH_W-1:0]  SH_MIN = SH_W'(SAT_MIN);
  localparam logic signed [ACC_W:0]   RND    = (ACC_W + 1)'(2048);

  logic signed [PROD_W-1:0] prod [8];
  logic signed [ACC_W-1:0]  acc  [8];
  logic signed [OUT_W-1:0]  sreg [8];

  function automatic logic signed [OUT_W-1:0] sat_round(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0]  r;
    logic signed [SH_W-1:0] s;
    r = (ACC_W + 1)'(a) + RND;
    s = SH_W'(r >>> 12);
    if (s > SH_MAX)
      return OUT_W'(SAT_MAX);
    else if (s < SH_MIN)
      return OUT_W'(SAT_MIN);
    else
      return s[OUT_W-1:0];
  endfunction

  always_comb begin
    for (int n = 0; n < 8; n++)
      prod[n] = PROD_W'(din) * PROD_W'(IDCT_C[n][phase]);
  end

  // phase 0 restarts accumulation and hands the finished vector to the shift-out register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 8; n++) begin
        acc[n]  <= '0;
        sreg[n] <= '0;
      end
    end else if (ena) begin
      if (phase == 3'd0) begin
        for (int n = 0; n < 8; n++) begin
          acc[n]  <= ACC_W'(prod[n]);
          sreg[n] <= sat_round(acc[n]);
        end
      end else begin
        for (int n = 0; n < 8; n++)
          acc[n] <= acc[n] + ACC_W'(prod[n]);
        for (int n = 0; n < 7; n++)
          sreg[n] <= sreg[n+1];
        sreg[7] <= '0;
      end
    end
  end

  assign dout = sreg[0];

endmodule

// File: rtl/idct_2d.sv
// rtl/idct_2d.sv - streaming 8x8 2D IDCT: column stage, banked transpose RAM, row stage
module idct_2d
  import dct_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [COEF_IN_W-1:0] in,
  input  logic                       ena,
  output logic signed [SAMPLE_W-1:0] out,
  output logic                       out_valid
);

  logic [5:0] in_cnt;
  logic [5:0] wcnt;
  logic       bank_sel;
  logic [6:0] warm;

  logic signed [MID_W-1:0]    s1_dout;
  logic signed [MID_W-1:0]    s2_din;
  logic signed [SAMPLE_W-1:0] s2_dout;
  logic signed [MID_W-1:0]    tbuf [128];

  // stage 1 output lags the input counter by 9, and stage 2 reads exactly one block later
  assign wcnt = in_cnt - 6'd9;

  idct_1d #(
    .IN_W(COEF_IN_W), .ACC_W(31), .OUT_W(MID_W),
    .SAT_MIN(-(2 ** (MID_W - 1))), .SAT_MAX(2 ** (MID_W - 1) - 1)
  ) u_col (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .phase(in_cnt[2:0]), .din(in), .dout(s1_dout)
  );

  always_ff @(posedge clk) begin
    if (ena)
      tbuf[{bank_sel, wcnt[2:0], wcnt[5:3]}] <= s1_dout;
  end

  assign s2_din = tbuf[{~bank_sel, wcnt}];

  idct_1d #(
    .IN_W(MID_W), .ACC_W(32), .OUT_W(SAMPLE_W),
    .SAT_MIN(-128), .SAT_MAX(127)
  ) u_row (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .phase(wcnt[2:0]), .din(s2_din), .dout(s2_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt    <= '0;
      bank_sel  <= 1'b0;
      warm      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else if (ena) begin
      in_cnt <= in_cnt + 6'd1;
      if (in_cnt == 6'd8)
        bank_sel <= ~bank_sel;
      // out holds 0 until the first real sample so unwritten RAM never leaks out
      if (warm != 7'(LATENCY - 1))
        warm <= warm + 7'd1;
      else begin
        out_valid <= 1'b1;
        out       <= s2_dout;
      end
    end
  end

endmodule
